// File: rtl/pixel_scan_pkg.sv
// ----------------------------------------------------------------------------
// pixel_scan_pkg
//   Shared types and default geometry for the pixel scan sequencer.
//   - scan_state_t : sequencer state encoding (IDLE, RUN, DONE)
//   - *_DEF        : default raster size, pixel slot period and counter widths
// ----------------------------------------------------------------------------
package pixel_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    localparam int H_PIX_DEF    = 640;
    localparam int V_PIX_DEF    = 480;
    localparam int TICK_DIV_DEF = 4;
    localparam int XW_DEF       = 10;
    localparam int YW_DEF       = 9;

endpackage

// File: rtl/pixel_tick_div.sv
// ----------------------------------------------------------------------------
// pixel_tick_div
//   Modulo-TICK_DIV counter that paces pixel slots.
// Ports
//   clk   in  system clock, rising edge
//   rst   in  synchronous reset, active-high
//   en    in  advance the count by one (wraps to 0 after TICK_DIV-1)
//   clr   in  force the count to 0; wins over en
//   term  out count is at its terminal value TICK_DIV-1
// ----------------------------------------------------------------------------
module pixel_tick_div #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic term
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;

    assign term = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= term ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pixel_scan_ctrl.sv
// ----------------------------------------------------------------------------
// pixel_scan_ctrl
//   Frame scan sequencer. On start, walks an H_PIX x V_PIX raster in
//   row-major order and offers one pixel slot every TICK_DIV clocks to a
//   downstream consumer over a valid/ready handshake.
// Ports
//   clk, rst        system clock / synchronous active-high reset
//   start           begin one frame (only looked at in IDLE)
//   abort           cancel the scan from any state
//   pix_ready       downstream accepts the presented pixel
//   pix_valid       pixel slot presented; pix_x/pix_y are valid
//   pix_x, pix_y    coordinates of the presented pixel
//   line_start      presented pixel is the first of its line
//   frame_end       presented pixel is the last of the frame
//   tick_en         enable for the pixel tick generator (RUN, not stalled)
//   busy            sequencer is not IDLE
//   done            one-cycle pulse after the last pixel is accepted
// ----------------------------------------------------------------------------
module pixel_scan_ctrl
    import pixel_scan_pkg::*;
#(
    parameter int H_PIX    = H_PIX_DEF,
    parameter int V_PIX    = V_PIX_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int XW       = XW_DEF,
    parameter int YW       = YW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          pix_ready,
    output logic          pix_valid,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          line_start,
    output logic          frame_end,
    output logic          tick_en,
    output logic          busy,
    output logic          done
);

    scan_state_t state, state_nxt;

    logic stall;
    logic accept;
    logic last_x;
    logic last_y;
    logic tick_clr;
    logic term;

    assign stall  = pix_valid & ~pix_ready;
    assign accept = pix_valid &  pix_ready;
    assign last_x = (pix_x == XW'(H_PIX - 1));
    assign last_y = (pix_y == YW'(V_PIX - 1));

    assign line_start = pix_valid & (pix_x == '0);
    assign frame_end  = pix_valid & last_x & last_y;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign tick_en    = (state == RUN) & ~stall;

    // The divider keeps counting through the accept cycle and wraps to 0 on
    // the edge that raises pix_valid, so it sits at 0 while a slot is
    // presented. That gives TICK_DIV clocks from RUN entry to the first slot
    // and TICK_DIV clocks from each accept cycle to the next slot.
    assign tick_clr = (state != RUN) | abort;

    pixel_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .clr  (tick_clr),
        .term (term)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start)                     state_nxt = RUN;
            RUN:  if (accept && last_x && last_y) state_nxt = DONE;
            DONE:                                state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
        // abort beats start and a coincident final accept
        if (abort) state_nxt = IDLE;
    end

    // ------------------------------------------------------------------
    // Handshake register and raster counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
        end else if (state == RUN) begin
            if (accept) begin
                pix_valid <= 1'b0;
                if (last_x) begin
                    pix_x <= '0;
                    pix_y <= last_y ? '0 : pix_y + YW'(1);
                end else begin
                    pix_x <= pix_x + XW'(1);
                end
            end else if (!pix_valid && term) begin
                pix_valid <= 1'b1;
            end
        end else begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    a_stall_hold: assert property (@(posedge clk) disable iff (rst)
        (pix_valid && !pix_ready && !abort && !rst)
            |=> (pix_valid && $stable(pix_x) && $stable(pix_y)));

    a_in_range: assert property (@(posedge clk) disable iff (rst)
        (int'(pix_x) < H_PIX) && (int'(pix_y) < V_PIX));

    a_done_pulse: assert property (@(posedge clk) disable iff (rst)
        done |=> !done);

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
module tb_pixel_scan_ctrl;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int T  = 4;
    localparam int XW = 10;
    localparam int YW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          pix_ready;
    logic          pix_valid;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          line_start;
    logic          frame_end;
    logic          tick_en;
    logic          busy;
    logic          done;

    pixel_scan_ctrl #(
        .H_PIX (H), .V_PIX (V), .TICK_DIV (T), .XW (XW), .YW (YW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .pix_ready  (pix_ready),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .line_start (line_start),
        .frame_end  (frame_end),
        .tick_en    (tick_en),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; } px_t;

    px_t exp_q[$];
    int  n_chk    = 0;
    int  n_fail   = 0;
    int  done_cnt = 0;
    bit  mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return {7'd0, pix_valid, line_start, frame_end, tick_en, busy, done, pix_x, pix_y};
    endfunction

    // Expected pixel order of one frame: row-major raster
    task automatic push_frame();
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                px_t p;
                p.x = x;
                p.y = y;
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns in the cycle where done is high; rnd randomizes pix_ready.
    task automatic wait_done(input int limit, input bit rnd);
        int k = 0;
        while (done !== 1'b1 && k < limit) begin
            if (rnd) pix_ready = ($urandom_range(0, 3) != 0);
            step(1);
            k++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        pix_ready = 1'b1;
    endtask

    task automatic wait_pix(input int x, input int y, input int limit);
        int k = 0;
        while (!(pix_valid === 1'b1 && int'(pix_x) == x && int'(pix_y) == y) && k < limit) begin
            step(1);
            k++;
        end
        check("pix_reached", {12'd0, pix_valid, pix_x, pix_y},
              {12'd0, 1'b1, XW'(x), YW'(y)});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard with a timing model:
    //   first slot  : TICK_DIV+1 cycles after the cycle start is taken
    //   later slots : TICK_DIV cycles after the previous accept cycle
    //   done        : the cycle after the last pixel's accept cycle
    //   abort / rst : everything zero the following cycle, frame discarded
    // ------------------------------------------------------------------
    int          cyc      = 0;
    int          due      = -1;
    int          done_due = -1;
    int          clr_due  = -1;
    bit          m_busy   = 1'b0;
    logic        p_valid  = 1'b0;
    logic        p_stall  = 1'b0;
    logic [XW-1:0] p_x    = '0;
    logic [YW-1:0] p_y    = '0;

    always @(negedge clk) begin
        px_t e;
        bit  acc;
        bit  last;
        if (mon_en) begin
            cyc++;
            last = 1'b0;
            if (pix_valid && !p_valid) check("rise_time", 32'(cyc), 32'(due));
            if (p_stall) check("stall_hold", {12'd0, pix_valid, pix_x, pix_y}, {12'd0, 1'b1, p_x, p_y});
            if (pix_valid && !pix_ready) check("stall_tick_en", {31'd0, tick_en}, 32'd0);
            if (done || cyc == done_due) check("done_pulse", {31'd0, done}, {31'd0, cyc == done_due});
            if (done_due >= 0 && cyc == done_due + 1) check("idle_gap_busy", {31'd0, busy}, 32'd0);
            if (cyc == clr_due) check("cleared", outs(), 32'd0);
            if (done) done_cnt++;

            acc = pix_valid && pix_ready && !abort && !rst;
            if (acc) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: got (%0d,%0d), expected none", pix_x, pix_y);
                end else begin
                    e = exp_q.pop_front();
                    last = (e.x == H - 1) && (e.y == V - 1);
                    check("pixel", {11'd0, pix_x, pix_y, line_start, frame_end},
                          {11'd0, XW'(e.x), YW'(e.y), e.x == 0, last});
                end
            end

            if (rst || abort) begin
                m_busy   = 1'b0;
                due      = -1;
                done_due = -1;
                clr_due  = cyc + 1;
                exp_q.delete();
            end else begin
                if (!m_busy && start) begin
                    m_busy = 1'b1;
                    due    = cyc + T + 1;
                end else if (acc) begin
                    if (last) begin
                        done_due = cyc + 1;
                        due      = -1;
                    end else begin
                        due = cyc + T;
                    end
                end
                if (cyc == done_due) m_busy = 1'b0;
            end

            p_valid = pix_valid;
            p_x     = pix_x;
            p_y     = pix_y;
            p_stall = pix_valid && !pix_ready && !abort && !rst;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int d0;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        pix_ready = 1'b0;
        step(3);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("reset_idle", outs(), 32'd0);
        end

        // Frame 1: ready tied high
        pix_ready = 1'b1;
        push_frame();
        pulse_start();
        wait_done(200, 1'b0);
        step(2);
        check("busy_after_frame", {31'd0, busy}, 32'd0);

        // Frame 2: 7-cycle stall on (1,0)
        push_frame();
        pulse_start();
        wait_pix(1, 0, 50);
        pix_ready = 1'b0;
        step(7);
        check("stall_still_valid", {12'd0, pix_valid, pix_x, pix_y}, {12'd0, 1'b1, XW'(1), YW'(0)});
        pix_ready = 1'b1;
        wait_done(200, 1'b0);
        step(3);

        // Frame 3: abort coincident with accept of (2,1)
        d0 = done_cnt;
        push_frame();
        pulse_start();
        wait_pix(2, 1, 100);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        step(10);
        check("abort_no_done", 32'(done_cnt), 32'(d0));

        // Frame 4: restart from (0,0) with random backpressure
        push_frame();
        pulse_start();
        wait_done(400, 1'b1);
        step(3);

        // Back-to-back frames with start held high
        push_frame();
        push_frame();
        start = 1'b1;
        wait_done(200, 1'b0);
        step(1);
        wait_done(200, 1'b0);
        start = 1'b0;
        step(2);
        check("b2b_idle_after", {31'd0, busy}, 32'd0);

        // rst mid-frame, then rst coincident with start
        push_frame();
        pulse_start();
        step(9);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);
        rst   = 1'b1;
        start = 1'b1;
        step(1);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy", {31'd0, busy}, 32'd0);
        step(T + 3);
        check("rst_start_ignored", outs(), 32'd0);

        // Final frame with random backpressure
        push_frame();
        pulse_start();
        wait_done(400, 1'b1);
        step(3);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(done_cnt), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
